glb_tile_pcfg_dma: RTL and testbench

Parallel-configuration DMA engine inside each global buffer tile. On a start pulse it streams a bitstream of {address, data} configuration words out of the tile's memory bank and converts each word into a CGRA configuration write packet. The packets feed the tile's parallel-configuration switch, which adds the tile column offset and forwards them to the CGRA.

---
 rtl/glb_tile_pcfg_dma.sv | 99 +++++++++
 tb/tb_glb_tile_pcfg_dma.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_tile_pcfg_dma.sv
// glb_tile_pcfg_dma: streams {addr,data} words from the tile bank into CGRA config write packets.
module glb_tile_pcfg_dma #(
    parameter int BANK_ADDR_WIDTH     = 17,
    parameter int BANK_DATA_WIDTH     = 64,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32,
    parameter int NUM_CFG_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_cfg_pcfg_dma_mode,
    input  logic [BANK_ADDR_WIDTH-1:0]     i_cfg_pcfg_start_addr,
    input  logic [NUM_CFG_WIDTH-1:0]       i_cfg_pcfg_num_cfg,
    input  logic                           i_pcfg_start_pulse,
    output logic                           o_bank_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0]     o_bank_rd_addr,
    input  logic [BANK_DATA_WIDTH-1:0]     i_bank_rd_data,
    input  logic                           i_bank_rd_data_valid,
    output logic                           o_cgra_cfg_c2sw_wr_en,
    output logic                           o_cgra_cfg_c2sw_rd_en,
    output logic [CGRA_CFG_ADDR_WIDTH-1:0] o_cgra_cfg_c2sw_addr,
    output logic [CGRA_CFG_DATA_WIDTH-1:0] o_cgra_cfg_c2sw_data,
    output logic                           o_pcfg_busy,
    output logic                           o_pcfg_done_pulse
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                     r_state;
    logic [1:0]                     w_next;
    logic [BANK_ADDR_WIDTH-1:0]     r_base;
    logic [NUM_CFG_WIDTH:0]         r_num;
    logic [NUM_CFG_WIDTH:0]         r_req_cnt;
    logic [NUM_CFG_WIDTH:0]         r_resp_cnt;
    logic                           r_wr_en;
    logic [CGRA_CFG_ADDR_WIDTH-1:0] r_addr;
    logic [CGRA_CFG_DATA_WIDTH-1:0] r_data;
    logic                           w_start;
    logic                           w_active;
    logic                           w_rd_en;
    logic                           w_resp;

    assign w_start  = i_pcfg_start_pulse && i_cfg_pcfg_dma_mode;
    // Gating with mode drops a response landing in the very cycle the engine is aborted.
    assign w_active = (r_state == S_READ || r_state == S_DRAIN) && i_cfg_pcfg_dma_mode;
    assign w_rd_en  = (r_state == S_READ) && (r_req_cnt != r_num);
    assign w_resp   = w_active && i_bank_rd_data_valid;

    // A zero-length job still spends one busy cycle in DRAIN so done lands two cycles after start.
    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_IDLE)
            w_next = w_start ? ((i_cfg_pcfg_num_cfg == '0) ? S_DRAIN : S_READ) : S_IDLE;
        else if (!i_cfg_pcfg_dma_mode && r_state != S_DONE)
            w_next = S_IDLE;
        else if (r_state == S_READ)
            w_next = w_rd_en ? S_READ : S_DRAIN;
        else if (r_state == S_DRAIN)
            w_next = (r_resp_cnt == r_num) ? S_DONE : S_DRAIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start) begin
                r_base     <= i_cfg_pcfg_start_addr & ~BANK_ADDR_WIDTH'(7);
                r_num      <= {1'b0, i_cfg_pcfg_num_cfg};
                r_req_cnt  <= '0;
                r_resp_cnt <= '0;
            end else begin
                if (w_rd_en) r_req_cnt <= r_req_cnt + 1'b1;
                if (w_resp) r_resp_cnt <= r_resp_cnt + 1'b1;
            end
            r_wr_en <= w_resp;
            r_addr  <= w_resp ? i_bank_rd_data[CGRA_CFG_ADDR_WIDTH+CGRA_CFG_DATA_WIDTH-1:CGRA_CFG_DATA_WIDTH] : '0;
            r_data  <= w_resp ? i_bank_rd_data[CGRA_CFG_DATA_WIDTH-1:0] : '0;
        end
    end

    assign o_bank_rd_en          = w_rd_en;
    assign o_bank_rd_addr        = w_rd_en ? r_base + BANK_ADDR_WIDTH'({r_req_cnt, 3'b000}) : '0;
    assign o_cgra_cfg_c2sw_wr_en = r_wr_en;
    assign o_cgra_cfg_c2sw_rd_en = 1'b0;
    assign o_cgra_cfg_c2sw_addr  = r_addr;
    assign o_cgra_cfg_c2sw_data  = r_data;
    assign o_pcfg_busy           = (r_state == S_READ) || (r_state == S_DRAIN);
    assign o_pcfg_done_pulse     = (r_state == S_DONE);
endmodule

// File: tb/tb_glb_tile_pcfg_dma.sv
// tb_glb_tile_pcfg_dma: randomized bank responder plus a transfer-level model of reads, packets, busy and done.
module tb_glb_tile_pcfg_dma;
    localparam int AW = 17;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [NW-1:0] num_cfg = '0;
    logic          start = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data = '0;
    logic          rd_valid = 1'b0;
    logic          wr_en;
    logic          c_rd_en;
    logic [31:0]   c_addr;
    logic [31:0]   c_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glb_tile_pcfg_dma dut (
        .clk                   (clk),
        .reset                 (reset),
        .i_cfg_pcfg_dma_mode   (mode),
        .i_cfg_pcfg_start_addr (start_addr),
        .i_cfg_pcfg_num_cfg    (num_cfg),
        .i_pcfg_start_pulse    (start),
        .o_bank_rd_en          (rd_en),
        .o_bank_rd_addr        (rd_addr),
        .i_bank_rd_data        (rd_data),
        .i_bank_rd_data_valid  (rd_valid),
        .o_cgra_cfg_c2sw_wr_en (wr_en),
        .o_cgra_cfg_c2sw_rd_en (c_rd_en),
        .o_cgra_cfg_c2sw_addr  (c_addr),
        .o_cgra_cfg_c2sw_data  (c_data),
        .o_pcfg_busy           (busy),
        .o_pcfg_done_pulse     (done)
    );

    typedef struct {int cyc; logic [31:0] a; logic [31:0] d;} pkt_t;
    typedef struct {int due; logic [63:0] w;} rsp_t;

    int            cyc;
    int            lmin = 2;
    int            lmax = 2;
    int            last_due;
    int            idle_junk;
    logic [31:0]   salt;
    rsp_t          pend[$];
    int            rd_cyc[$];
    logic [AW-1:0] rd_adr[$];
    pkt_t          wr_log[$];
    pkt_t          vld_log[$];
    int            done_cyc[$];
    int            busy_cyc[$];

    // Bank contents are a salted function of the byte address.
    function automatic logic [63:0] word_of(input logic [AW-1:0] a);
        return {salt ^ {15'h0, a}, ~salt + {15'h0, a} * 32'd7};
    endfunction

    // One clock: sample the cycle's outputs, then play the bank for this cycle.
    task automatic step();
        logic [63:0] w;
        int lat;
        @(negedge clk);
        cyc++;
        if (rd_en) begin
            lat = int'($urandom_range(lmax, lmin));
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{last_due, word_of(rd_addr)});
            rd_cyc.push_back(cyc);
            rd_adr.push_back(rd_addr);
        end
        if (wr_en) wr_log.push_back('{cyc, c_addr, c_data});
        else if (c_addr !== '0 || c_data !== '0) idle_junk++;
        if (c_rd_en !== 1'b0) idle_junk++;
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_cyc.push_back(cyc);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            w = pend[0].w;
            void'(pend.pop_front());
            rd_valid = 1'b1;
            rd_data = w;
            vld_log.push_back('{cyc, w[63:32], w[31:0]});
        end else begin
            rd_valid = 1'b0;
            rd_data = {$urandom, $urandom};
        end
    endtask

    task automatic kick(input logic [NW-1:0] n, input logic [AW-1:0] a);
        pend.delete(); rd_cyc.delete(); rd_adr.delete(); wr_log.delete();
        vld_log.delete(); done_cyc.delete(); busy_cyc.delete();
        cyc = 0; last_due = -100; idle_junk = 0;
        num_cfg = n; start_addr = a; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin step(); k++; end
        repeat (3) step();
    endtask

    task automatic test_reset();
        mode = 1'b1; start = 1'b1; num_cfg = 16'd3;
        step();
        checks++;
        if ({rd_en, rd_addr, wr_en, c_rd_en, c_addr, c_data, busy, done} !== '0) begin
            errors++; $display("FAIL reset_outputs got rd_en=%b busy=%b done=%b wr_en=%b want all 0", rd_en, busy, done, wr_en);
        end
        start = 1'b0; reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_release got busy=%b rd_en=%b want 0 0", busy, rd_en);
        end
    endtask

    task automatic test_basic();
        logic [63:0] w;
        lmin = 2; lmax = 2;
        kick(16'd4, 17'h100);
        run_until_done(40);
        checks++;
        if (rd_cyc.size() != 4) begin errors++; $display("FAIL basic_rd_count got %0d want 4", rd_cyc.size()); end
        for (int i = 0; i < rd_cyc.size() && i < 4; i++) begin
            checks++;
            if (rd_cyc[i] != i + 1 || rd_adr[i] !== 17'h100 + 17'(8 * i)) begin
                errors++; $display("FAIL basic_rd[%0d] got cyc %0d addr %h want cyc %0d addr %h", i, rd_cyc[i], rd_adr[i], i + 1, 17'h100 + 17'(8 * i));
            end
        end
        checks++;
        if (wr_log.size() != 4) begin errors++; $display("FAIL basic_pkt_count got %0d want 4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < 4; i++) begin
            w = word_of(17'h100 + 17'(8 * i));
            checks++;
            if (wr_log[i].cyc != i + 4 || wr_log[i].a !== w[63:32] || wr_log[i].d !== w[31:0]) begin
                errors++; $display("FAIL basic_pkt[%0d] got cyc %0d %h/%h want cyc %0d %h/%h", i, wr_log[i].cyc, wr_log[i].a, wr_log[i].d, i + 4, w[63:32], w[31:0]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 8) begin
            errors++; $display("FAIL basic_done got %0d pulses first %0d want 1 pulse at 8", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (busy_cyc.size() != 7 || busy_cyc[0] != 1 || busy_cyc[$] != 7) begin
            errors++; $display("FAIL basic_busy got %0d cycles want cycles 1..7", busy_cyc.size());
        end
    endtask

    task automatic test_zero();
        kick(16'd0, AW'($urandom));
        run_until_done(10);
        checks++;
        if (rd_cyc.size() != 0 || wr_log.size() != 0) begin
            errors++; $display("FAIL zero_traffic got %0d reads %0d packets want 0 0", rd_cyc.size(), wr_log.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 2) begin
            errors++; $display("FAIL zero_done got %0d pulses first %0d want 1 pulse at 2", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (busy_cyc.size() != 1 || busy_cyc[0] != 1) begin
            errors++; $display("FAIL zero_busy got %0d cycles want only cycle 1", busy_cyc.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        logic [63:0] w;
        exp_a = '{17'h1FFF0, 17'h1FFF8, 17'h00000, 17'h00008};
        lmin = 1; lmax = 3;
        kick(16'd4, 17'h1FFF3);
        run_until_done(40);
        checks++;
        if (rd_adr.size() != 4) begin errors++; $display("FAIL wrap_rd_count got %0d want 4", rd_adr.size()); end
        for (int i = 0; i < rd_adr.size() && i < 4; i++) begin
            checks++;
            if (rd_adr[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_rd[%0d] got %h want %h", i, rd_adr[i], exp_a[i]); end
        end
        checks++;
        if (wr_log.size() != 4) begin errors++; $display("FAIL wrap_pkt_count got %0d want 4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < 4; i++) begin
            w = word_of(exp_a[i]);
            checks++;
            if (wr_log[i].a !== w[63:32] || wr_log[i].d !== w[31:0]) begin
                errors++; $display("FAIL wrap_pkt[%0d] got %h/%h want %h/%h", i, wr_log[i].a, wr_log[i].d, w[63:32], w[31:0]);
            end
        end
    endtask

    task automatic test_latency();
        logic [AW-1:0] base;
        logic [63:0] w;
        base = AW'($urandom) & ~AW'(7);
        lmin = 1; lmax = 5;
        kick(16'd32, base | AW'($urandom_range(7, 0)));
        run_until_done(200);
        checks++;
        if (rd_cyc.size() != 32 || rd_cyc[0] != 1 || rd_cyc[$] != 32) begin
            errors++; $display("FAIL lat_reads got %0d reads want 32 in cycles 1..32", rd_cyc.size());
        end
        checks++;
        if (wr_log.size() != 32) begin errors++; $display("FAIL lat_pkt_count got %0d want 32", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < 32 && i < vld_log.size(); i++) begin
            w = word_of(base + AW'(8 * i));
            checks++;
            if (wr_log[i].cyc != vld_log[i].cyc + 1 || wr_log[i].a !== w[63:32] || wr_log[i].d !== w[31:0]) begin
                errors++; $display("FAIL lat_pkt[%0d] got cyc %0d %h/%h want cyc %0d %h/%h", i, wr_log[i].cyc, wr_log[i].a, wr_log[i].d, vld_log[i].cyc + 1, w[63:32], w[31:0]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || vld_log.size() == 0 || done_cyc[0] != vld_log[$].cyc + 2) begin
            errors++; $display("FAIL lat_done got %0d pulses first %0d want 1 pulse at %0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, vld_log.size() ? vld_log[$].cyc + 2 : -1);
        end
        checks++;
        if (idle_junk != 0) begin errors++; $display("FAIL lat_idle_outputs got %0d nonzero idle cycles want 0", idle_junk); end
    endtask

    task automatic test_abort();
        lmin = 4; lmax = 4;
        kick(16'd8, 17'h2000);
        repeat (2) step();
        mode = 1'b0;
        step();
        checks++;
        if (rd_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_stop got rd_en=%b busy=%b want 0 0", rd_en, busy);
        end
        repeat (10) step();
        checks++;
        if (rd_cyc.size() != 3 || wr_log.size() != 0 || done_cyc.size() != 0) begin
            errors++; $display("FAIL abort_quiet got %0d reads %0d packets %0d dones want 3 0 0", rd_cyc.size(), wr_log.size(), done_cyc.size());
        end
        lmin = 1; lmax = 3;
        kick(16'd5, 17'h0040);
        run_until_done(60);
        checks++;
        if (rd_cyc.size() != 5 || wr_log.size() != 5 || done_cyc.size() != 1) begin
            errors++; $display("FAIL abort_restart got %0d reads %0d packets %0d dones want 5 5 1", rd_cyc.size(), wr_log.size(), done_cyc.size());
        end
    endtask

    task automatic test_ignored_start();
        lmin = 2; lmax = 2;
        kick(16'd6, 17'h0800);
        repeat (2) step();
        start = 1'b1; num_cfg = 16'd2; start_addr = 17'h1000;
        step();
        start = 1'b0;
        run_until_done(60);
        checks++;
        if (rd_cyc.size() != 6 || rd_adr[$] !== 17'h0828) begin
            errors++; $display("FAIL ign_reads got %0d reads last %h want 6 last 00828", rd_cyc.size(), rd_adr[$]);
        end
        checks++;
        if (wr_log.size() != 6 || done_cyc.size() != 1 || done_cyc[0] != 10) begin
            errors++; $display("FAIL ign_done got %0d packets %0d dones first %0d want 6 1 at 10", wr_log.size(), done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_drain();
        lmin = 5; lmax = 5;
        kick(16'd3, 17'h0300);
        repeat (4) step();
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_drain_pre got busy=%b rd_en=%b want 1 0", busy, rd_en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({rd_en, rd_addr, wr_en, c_addr, c_data, busy, done} !== '0) begin
            errors++; $display("FAIL rst_drain_async got busy=%b rd_en=%b wr_en=%b want all 0", busy, rd_en, wr_en);
        end
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();
        checks++;
        if (wr_log.size() != 0 || done_cyc.size() != 0) begin
            errors++; $display("FAIL rst_drain_post got %0d packets %0d dones want 0 0", wr_log.size(), done_cyc.size());
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_latency();
        test_abort();
        test_ignored_start();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
